// File: rtl/memory_ctrl_if.sv
// Request/response bus for memory_ctrl; the requester uses master, the memory uses slave.
// Optional MEM_PARITY_EN adds the req_perr_inject request field.
interface memory_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
`ifdef MEM_PARITY_EN
    logic              req_perr_inject;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              clr_req;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
`ifdef MEM_PARITY_EN
        output req_perr_inject,
`endif
        output rsp_ready, clr_req,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
`ifdef MEM_PARITY_EN
        input  req_perr_inject,
`endif
        input  rsp_ready, clr_req,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/memory_ctrl.sv
// Single-port word memory with valid/ready requests, a registered 1-cycle read
// response with back-pressure, out-of-range detection and a clear sequencer.
// Optional feature macro: MEM_PARITY_EN (per-word even parity, error injection).
module memory_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    memory_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = DEPTH_L - (ADDR_W+1)'(1);

    typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_t;

    logic [MEM_W-1:0]  mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic              req_ready_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  req_idx_c;
    logic [MEM_W-1:0]  rd_word_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              rd_err_c;
    logic [MEM_W-1:0]  wr_word_c;
    logic              mem_we_c;
    logic [IDX_W-1:0]  mem_idx_c;
    logic [MEM_W-1:0]  mem_wword_c;

    // Address decode, read-word lookup and write-word formation
    always_comb begin
        in_range_c = ({1'b0, bus.req_addr} < DEPTH_L);
        req_idx_c  = IDX_W'(bus.req_addr);
        rd_word_c  = mem[req_idx_c];
        rd_data_c  = in_range_c ? rd_word_c[DATA_W-1:0] : '0;
`ifdef MEM_PARITY_EN
        rd_err_c   = !in_range_c || (rd_word_c[DATA_W] != (^rd_word_c[DATA_W-1:0]));
        wr_word_c  = {(^bus.req_wdata) ^ bus.req_perr_inject, bus.req_wdata};
`else
        rd_err_c   = !in_range_c;
        wr_word_c  = bus.req_wdata;
`endif
    end

    // Next-state, response and memory-write control
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_c = 1'b0;
        mem_we_c    = 1'b0;
        mem_idx_c   = req_idx_c;
        mem_wword_c = wr_word_c;

        case (state_q)
            CLEAR: begin
                mem_we_c    = 1'b1;
                mem_idx_c   = IDX_W'(clr_addr_q);
                mem_wword_c = '0;
                clr_addr_d  = clr_addr_q + (ADDR_W+1)'(1);
                if (clr_addr_q == LAST_L) state_d = IDLE;
            end
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (bus.req_write) begin
                        mem_we_c = in_range_c;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rd_data_c;
                        rsp_err_d   = rd_err_c;
                        state_d     = RESP;
                    end
                end else if (bus.clr_req) begin
                    clr_addr_d = '0;
                    state_d    = CLEAR;
                end
            end
            RESP: begin
                req_ready_c = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                    if (bus.req_valid) begin
                        if (bus.req_write) begin
                            mem_we_c = in_range_c;
                        end else begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = rd_data_c;
                            rsp_err_d   = rd_err_c;
                            state_d     = RESP;
                        end
                    end
                end
            end
            default: state_d = CLEAR;
        endcase

        busy_d = (state_d == CLEAR);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_idx_c] <= mem_wword_c;
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench for memory_ctrl (DATA_W=16, ADDR_W=8, DEPTH=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_memory_ctrl;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   cnt;
    logic saw_ready;

    memory_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    memory_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] a, input logic [15:0] d, input logic inj);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
`ifdef MEM_PARITY_EN
        bus.req_perr_inject = inj;
`else
        if (inj) $display("note: inject ignored without parity");
`endif
        #1 chk("wr_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
`ifdef MEM_PARITY_EN
        bus.req_perr_inject = 1'b0;
`endif
    endtask

    task automatic read_word(input logic [7:0] a, input logic [15:0] exp_d, input logic exp_e);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rd_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_data", 32'(bus.rsp_rdata), 32'(exp_d));
        chk("rd_err", 32'(bus.rsp_err), 32'(exp_e));
    endtask

    task automatic count_busy(input string tag);
        cnt = 0;
        saw_ready = 1'b0;
        while (bus.busy && cnt < 100) begin
            if (bus.req_ready) saw_ready = 1'b1;
            @(negedge clk);
            cnt++;
        end
        chk(tag, 32'(cnt), 32'd16);
        chk("ready_low_in_clear", 32'(saw_ready), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus.clr_req   = 1'b0;
`ifdef MEM_PARITY_EN
        bus.req_perr_inject = 1'b0;
`endif

        // Reset values
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);

        // Clear after reset release takes DEPTH cycles, array reads zero
        @(negedge clk);
        reset = 1'b1;
        count_busy("init_clear_cycles");
        for (int i = 0; i < 16; i++) read_word(8'(i), 16'h0000, 1'b0);

        // Simple write then read
        write_word(8'd5, 16'hBEEF, 1'b0);
        read_word(8'd5, 16'hBEEF, 1'b0);

        // Back-to-back reads, one response per cycle
        write_word(8'd1, 16'h0011, 1'b0);
        write_word(8'd2, 16'h0022, 1'b0);
        write_word(8'd3, 16'h0033, 1'b0);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd1;
        @(negedge clk);
        chk("b2b_0", 32'(bus.rsp_rdata), 32'h0011);
        bus.req_addr = 8'd2;
        #1 chk("b2b_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("b2b_1", 32'(bus.rsp_rdata), 32'h0022);
        bus.req_addr = 8'd3;
        @(negedge clk);
        chk("b2b_2", 32'(bus.rsp_rdata), 32'h0033);
        chk("b2b_valid", 32'(bus.rsp_valid), 32'd1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", 32'(bus.rsp_valid), 32'd0);

        // Response held under back-pressure
        write_word(8'd7, 16'h1234, 1'b0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_data", 32'(bus.rsp_rdata), 32'h1234);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1 chk("release_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("release_rdata_kept", 32'(bus.rsp_rdata), 32'h1234);

        // Out-of-range write ignored, read flags error
        write_word(8'd20, 16'hAAAA, 1'b0);
        read_word(8'd20, 16'h0000, 1'b1);
        read_word(8'd4, 16'h0000, 1'b0);
        @(negedge clk);
        chk("err_cleared", 32'(bus.rsp_err), 32'd0);

        // Software clear
        write_word(8'd3, 16'h5555, 1'b0);
        read_word(8'd3, 16'h5555, 1'b0);
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        count_busy("sw_clear_cycles");
        read_word(8'd3, 16'h0000, 1'b0);

        // Clear request coinciding with a write is dropped
        @(negedge clk);
        bus.clr_req   = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'd6;
        bus.req_wdata = 16'h6666;
        @(negedge clk);
        bus.clr_req   = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        chk("clr_dropped", 32'(bus.busy), 32'd0);
        read_word(8'd6, 16'h6666, 1'b0);

`ifdef MEM_PARITY_EN
        // Parity error injection
        write_word(8'd2, 16'h0001, 1'b1);
        read_word(8'd2, 16'h0001, 1'b1);
        write_word(8'd2, 16'h0001, 1'b0);
        read_word(8'd2, 16'h0001, 1'b0);
`endif

        // Reset during a pending response
        write_word(8'd5, 16'hCAFE, 1'b0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pend_valid", 32'(bus.rsp_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd1);
        chk("midrst_rdata", 32'(bus.rsp_rdata), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        count_busy("rst_clear_cycles");
        read_word(8'd5, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
